mult_div_unit: RTL and testbench

- Multicycle sequencer for the signed MULT/DIV instructions of the multicycle CPU; owns the HI/LO result registers.
- The main control unit pulses a start, waits on busy/done, then reads hi/lo for MFHI/MFLO.
- Operands come from the A/B register outputs.
- Multiply is radix-2 Booth; divide is restoring division on magnitudes with a sign fix-up.

---
 rtl/mult_div_unit.sv | 180 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed MULT/DIV sequencer owning the HI/LO registers.
//   Multiply: radix-2 Booth, WIDTH iterations. Divide: restoring division on
//   magnitudes, WIDTH iterations, then sign fix-up folded into the last cycle.
// Ports:
//   clk, reset (async, active low)
//   start_mult, start_div : operation requests, sampled only in IDLE
//   a, b                  : operands, captured on the accepting edge
//   busy                  : high while iterating
//   done, div_zero        : one-cycle completion pulses (div_zero only on b==0)
//   hi, lo                : mult {hi,lo}=product; div hi=remainder, lo=quotient
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_FIN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // acc is one bit wider than the operands so that Booth's +/-m never
  // overflows (e.g. subtracting -2^(W-1)); in divide it holds the remainder.
  logic [WIDTH:0]   acc_q, acc_d, m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d, hi_q, hi_d, lo_q, lo_d;
  logic             q1_q, q1_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   bsum, b_acc, shl, d_rem;
  logic [WIDTH-1:0] b_q, d_quo, quo_fix, rem_fix;
  logic [WIDTH+1:0] diff;
  logic             fits, last;

  assign abs_a = a[WIDTH-1] ? -a : a;
  assign abs_b = b[WIDTH-1] ? -b : b;
  assign last  = (cnt_q == CW'(1));

  // Booth step: add/sub on the pair {q[0],q_1}, then arithmetic shift right.
  always_comb begin
    case ({q_q[0], q1_q})
      2'b01:   bsum = acc_q + m_q;
      2'b10:   bsum = acc_q - m_q;
      default: bsum = acc_q;
    endcase
  end
  assign b_acc = {bsum[WIDTH], bsum[WIDTH:1]};
  assign b_q   = {bsum[0], q_q[WIDTH-1:1]};

  // Restoring step: shift {rem,quo} left, keep the trial difference if >= 0.
  assign shl     = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign diff    = {1'b0, shl} - {1'b0, m_q};
  assign fits    = ~diff[WIDTH+1];
  assign d_rem   = fits ? diff[WIDTH:0] : shl;
  assign d_quo   = {q_q[WIDTH-2:0], fits};
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign quo_fix = qneg_q ? -d_quo : d_quo;
  assign rem_fix = rneg_q ? -d_rem[WIDTH-1:0] : d_rem[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_mult) begin
          state_d = S_MULT;
          cnt_d   = CW'(WIDTH);
          acc_d   = '0;
          q_d     = a;
          q1_d    = 1'b0;
          m_d     = {b[WIDTH-1], b};
          busy_d  = 1'b1;
        end else if (start_div) begin
          if (b != '0) begin
            state_d = S_DIV;
            cnt_d   = CW'(WIDTH);
            acc_d   = '0;
            q_d     = abs_a;
            m_d     = {1'b0, abs_b};
            qneg_d  = a[WIDTH-1] ^ b[WIDTH-1];
            rneg_d  = a[WIDTH-1];
            busy_d  = 1'b1;
          end else begin
            // Divide by zero: finish at once, HI/LO untouched.
            state_d = S_FIN;
            done_d  = 1'b1;
            dz_d    = 1'b1;
          end
        end
      end
      S_MULT: begin
        acc_d = b_acc;
        q_d   = b_q;
        q1_d  = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          state_d = S_FIN;
          done_d  = 1'b1;
          hi_d    = b_acc[WIDTH-1:0];
          lo_d    = b_q;
        end else begin
          busy_d  = 1'b1;
        end
      end
      S_DIV: begin
        acc_d = d_rem;
        q_d   = d_quo;
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          state_d = S_FIN;
          done_d  = 1'b1;
          hi_d    = rem_fix;
          lo_d    = quo_fix;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the driver pushes the expected HI/LO,
// div_zero flag and completion cycle; a negedge monitor pops on every done.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_mult = 1'b0, start_div = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(rst_n), .start_mult(start_mult), .start_div(start_div),
    .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && done) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done cyc=%0d hi=%h lo=%h", cyc, hi, lo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz || busy !== 1'b0 || cyc != e.cyc) begin
          fails++;
          $display("FAIL result got hi=%h lo=%h dz=%b busy=%b cyc=%0d, want hi=%h lo=%h dz=%b busy=0 cyc=%0d",
                   hi, lo, div_zero, busy, cyc, e.hi, e.lo, e.dz, e.cyc);
        end
      end
    end
    if (rst_n && div_zero && !done) begin
      tests++;
      fails++;
      $display("FAIL div_zero_without_done cyc=%0d", cyc);
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout %0d results never arrived", sb.size());
      sb.delete();
    end
  endtask

  task automatic op(input logic mul, input logic dv, input logic [W-1:0] aa, input logic [W-1:0] bb,
                    input logic [W-1:0] eh, input logic [W-1:0] el, input logic dz);
    @(negedge clk);
    start_mult = mul;
    start_div  = dv;
    a = aa;
    b = bb;
    sb.push_back('{hi: eh, lo: el, dz: dz, cyc: dz ? cyc + 1 : cyc + 1 + W});
    @(posedge clk);
    #1 start_mult = 1'b0;
    start_div = 1'b0;
    wait_drain();
  endtask

  initial begin
    int n;
    int seen;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    rst_n = 1'b1;

    // Multiply
    op(1, 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    op(1, 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0);
    op(1, 0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 0);

    // Divide signs
    op(0, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    op(0, 1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 0);
    op(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 0);

    // Divide by zero keeps the preloaded multiply result
    op(1, 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    op(0, 1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1);

    // Both starts together: multiply wins (5*6=30, divide would give 0 r5)
    op(1, 1, 32'd5, 32'd6, 32'd0, 32'd30, 0);

    // start_div mid-multiply is ignored: 1000 * -1000 = -1000000
    @(negedge clk);
    start_mult = 1'b1;
    a = 32'd1000;
    b = 32'hFFFFFC18;
    sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFF0BDC0, dz: 1'b0, cyc: cyc + 1 + W});
    @(posedge clk);
    #1 start_mult = 1'b0;
    repeat (10) @(posedge clk);
    #1 start_div = 1'b1;
    a = 32'd3;
    b = 32'd1;
    @(posedge clk);
    #1 start_div = 1'b0;
    wait_drain();

    // Operands scrambled every cycle after acceptance: 100/9 = 11 r1
    @(negedge clk);
    start_div = 1'b1;
    a = 32'd100;
    b = 32'd9;
    sb.push_back('{hi: 32'd1, lo: 32'd11, dz: 1'b0, cyc: cyc + 1 + W});
    @(posedge clk);
    #1 start_div = 1'b0;
    repeat (W + 2) begin
      @(posedge clk);
      #1 a = $urandom;
      b = $urandom | 32'd1;
    end
    wait_drain();

    // start_div held high: back-to-back divides, done pulses W+2 apart
    @(negedge clk);
    start_div = 1'b1;
    a = 32'hFFFFFFF9;
    b = 32'd2;
    n = cyc + 1;
    sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD, dz: 1'b0, cyc: n + W});
    sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD, dz: 1'b0, cyc: n + 2 * W + 2});
    repeat (W + 3) @(posedge clk);
    #1 start_div = 1'b0;
    wait_drain();

    // Reset mid-multiply: outputs clear at once, no done afterwards
    @(negedge clk);
    start_mult = 1'b1;
    a = 32'd7;
    b = 32'hFFFFFFFD;
    @(posedge clk);
    #1 start_mult = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_hi", hi, 32'd0);
    check("midreset_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("midreset_no_done", seen, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
